// File: rtl/vs_mp_iteration_sequencer.sv
// Matching-pursuit iteration sequencer: copies y into the residual, then runs up to K sweep/identify/update rounds.
// Define VS_MP_EARLY_STOP_EN to end a run early when the selected |mi_value| falls below threshold.
`ifndef SIGNAL_SIZE_DEFAULT
`define SIGNAL_SIZE_DEFAULT 16
`endif
`ifndef DICTIONARY_SIZE_DEFAULT
`define DICTIONARY_SIZE_DEFAULT 64
`endif
`ifndef SPARSITY_LEVEL_DEFAULT
`define SPARSITY_LEVEL_DEFAULT 8
`endif
`ifndef FP_DATA_BUS_WIDTH
`define FP_DATA_BUS_WIDTH 16
`endif

module vs_mp_iteration_sequencer #(
    parameter int unsigned M  = `SIGNAL_SIZE_DEFAULT,
    parameter int unsigned N  = `DICTIONARY_SIZE_DEFAULT,
    parameter int unsigned K  = `SPARSITY_LEVEL_DEFAULT,
    parameter int unsigned DW = `FP_DATA_BUS_WIDTH,
    localparam int unsigned SAW = $clog2(M),
    localparam int unsigned RAW = $clog2(N),
    localparam int unsigned KW  = $clog2(K + 2)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    output logic           done,
    output logic           busy,
    output logic [KW-1:0]  iterations,
    output logic           stopped,
    input  logic [DW-1:0]  threshold,
    output logic [SAW-1:0] y_read_addr,
    input  logic [DW-1:0]  y_read_data,
    output logic           r_write_en,
    output logic [SAW-1:0] r_write_addr,
    output logic [DW-1:0]  r_write_data,
    output logic           dp_start,
    input  logic           dp_done,
    input  logic           mi_valid,
    input  logic [RAW-1:0] mi_location,
    input  logic [DW-1:0]  mi_value,
    output logic [RAW-1:0] x_read_addr,
    input  logic [DW-1:0]  x_read_data,
    output logic           x_write_en,
    output logic [RAW-1:0] x_write_addr,
    output logic [DW-1:0]  x_write_data,
    output logic           ru_start,
    output logic [RAW-1:0] ru_location,
    output logic [DW-1:0]  ru_coeff,
    input  logic           ru_done
);

    localparam int unsigned CW = SAW + 1;

    typedef enum logic [3:0] {
        IDLE,
        COPY,
        SWEEP,
        IDENT,
        X_READ,
        X_WRITE,
        RES_UPD,
        CHECK,
        FINISH
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [KW-1:0]  iter_q, iter_d;
    logic           stopped_q, stopped_d;
    logic           mi_pend_q, mi_pend_d;
    logic [RAW-1:0] loc_q, loc_d;
    logic [DW-1:0]  val_q, val_d;
    logic [DW-1:0]  x_sum_q, x_sum_d;

    logic           done_q, done_d;
    logic           busy_q, busy_d;
    logic [SAW-1:0] y_read_addr_q, y_read_addr_d;
    logic           r_write_en_q, r_write_en_d;
    logic [SAW-1:0] r_write_addr_q, r_write_addr_d;
    logic           dp_start_q, dp_start_d;
    logic [RAW-1:0] x_read_addr_q, x_read_addr_d;
    logic           x_write_en_q, x_write_en_d;
    logic [RAW-1:0] x_write_addr_q, x_write_addr_d;
    logic [DW-1:0]  x_write_data_q, x_write_data_d;
    logic           ru_start_q, ru_start_d;
    logic [RAW-1:0] ru_location_q, ru_location_d;
    logic [DW-1:0]  ru_coeff_q, ru_coeff_d;

    logic [DW-1:0]  cand_val_c;
    logic           early_stop_c;

    // Candidate coefficient: the latched sweep result wins over the live input.
`ifdef VS_MP_EARLY_STOP_EN
    logic [DW-1:0] cand_mag_c;

    always_comb begin
        cand_val_c   = mi_pend_q ? val_q : mi_value;
        cand_mag_c   = cand_val_c[DW-1] ? DW'(-cand_val_c) : cand_val_c;
        early_stop_c = (cand_mag_c < threshold);
    end
`else
    logic unused_threshold;
    assign unused_threshold = ^threshold;

    always_comb begin
        cand_val_c   = mi_pend_q ? val_q : mi_value;
        early_stop_c = 1'b0;
    end
`endif

    // Next-state, datapath and look-ahead output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        iter_d    = iter_q;
        stopped_d = stopped_q;
        mi_pend_d = mi_pend_q;
        loc_d     = loc_q;
        val_d     = val_q;
        x_sum_d   = x_sum_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    iter_d    = '0;
                    stopped_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = COPY;
                end
            end
            COPY: begin
                if (cnt_q == CW'(M)) begin
                    cnt_d   = '0;
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CHECK: begin
                if (iter_q == KW'(K)) begin
                    state_d = FINISH;
                end else begin
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                if (mi_valid) begin
                    mi_pend_d = 1'b1;
                    loc_d     = mi_location;
                    val_d     = mi_value;
                end
                if (dp_done) begin
                    state_d = IDENT;
                end
            end
            IDENT: begin
                if (mi_pend_q || mi_valid) begin
                    mi_pend_d = 1'b0;
                    val_d     = cand_val_c;
                    if (!mi_pend_q) begin
                        loc_d = mi_location;
                    end
                    if (early_stop_c) begin
                        stopped_d = 1'b1;
                        state_d   = FINISH;
                    end else begin
                        cnt_d   = '0;
                        state_d = X_READ;
                    end
                end
            end
            X_READ: begin
                // Cycle 0 presents the address; cycle 1 sees the RAM data.
                if (cnt_q != '0) begin
                    x_sum_d = x_read_data + val_q;
                    cnt_d   = '0;
                    state_d = X_WRITE;
                end else begin
                    cnt_d = CW'(1);
                end
            end
            X_WRITE: begin
                state_d = RES_UPD;
            end
            RES_UPD: begin
                if (ru_done) begin
                    iter_d  = iter_q + KW'(1);
                    state_d = CHECK;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d         = (state_d != IDLE);
        done_d         = (state_d == FINISH);
        y_read_addr_d  = '0;
        r_write_en_d   = 1'b0;
        r_write_addr_d = '0;
        if (state_d == COPY) begin
            if (cnt_d < CW'(M)) begin
                y_read_addr_d = SAW'(cnt_d);
            end
            if (cnt_d != '0) begin
                r_write_en_d   = 1'b1;
                r_write_addr_d = SAW'(cnt_d - CW'(1));
            end
        end
        dp_start_d     = (state_q == CHECK) && (state_d == SWEEP);
        x_read_addr_d  = ((state_d == X_READ) && (cnt_d == '0)) ? loc_d : '0;
        x_write_en_d   = (state_d == X_WRITE);
        x_write_addr_d = x_write_en_d ? loc_d : '0;
        x_write_data_d = x_write_en_d ? x_sum_d : '0;
        ru_start_d     = (state_q == X_WRITE) && (state_d == RES_UPD);
        ru_location_d  = (state_d == RES_UPD) ? loc_d : '0;
        ru_coeff_d     = (state_d == RES_UPD) ? val_d : '0;
    end

    // State, datapath and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            iter_q         <= '0;
            stopped_q      <= 1'b0;
            mi_pend_q      <= 1'b0;
            loc_q          <= '0;
            val_q          <= '0;
            x_sum_q        <= '0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
            y_read_addr_q  <= '0;
            r_write_en_q   <= 1'b0;
            r_write_addr_q <= '0;
            dp_start_q     <= 1'b0;
            x_read_addr_q  <= '0;
            x_write_en_q   <= 1'b0;
            x_write_addr_q <= '0;
            x_write_data_q <= '0;
            ru_start_q     <= 1'b0;
            ru_location_q  <= '0;
            ru_coeff_q     <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            iter_q         <= iter_d;
            stopped_q      <= stopped_d;
            mi_pend_q      <= mi_pend_d;
            loc_q          <= loc_d;
            val_q          <= val_d;
            x_sum_q        <= x_sum_d;
            done_q         <= done_d;
            busy_q         <= busy_d;
            y_read_addr_q  <= y_read_addr_d;
            r_write_en_q   <= r_write_en_d;
            r_write_addr_q <= r_write_addr_d;
            dp_start_q     <= dp_start_d;
            x_read_addr_q  <= x_read_addr_d;
            x_write_en_q   <= x_write_en_d;
            x_write_addr_q <= x_write_addr_d;
            x_write_data_q <= x_write_data_d;
            ru_start_q     <= ru_start_d;
            ru_location_q  <= ru_location_d;
            ru_coeff_q     <= ru_coeff_d;
        end
    end

    assign done         = done_q;
    assign busy         = busy_q;
    assign iterations   = iter_q;
    assign stopped      = stopped_q;
    assign y_read_addr  = y_read_addr_q;
    assign r_write_en   = r_write_en_q;
    assign r_write_addr = r_write_addr_q;
    // y RAM data lands in the cycle the write strobe is up, so it is forwarded, not re-registered.
    assign r_write_data = r_write_en_q ? y_read_data : '0;
    assign dp_start     = dp_start_q;
    assign x_read_addr  = x_read_addr_q;
    assign x_write_en   = x_write_en_q;
    assign x_write_addr = x_write_addr_q;
    assign x_write_data = x_write_data_q;
    assign ru_start     = ru_start_q;
    assign ru_location  = ru_location_q;
    assign ru_coeff     = ru_coeff_q;

endmodule
